uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte interface among NUM_REQ requesters at packet granularity.
- Round-robin grant, optional per-packet header byte carrying requester ID, and a max-length guard so no requester monopolises the line.
- Sits between debug sources (packet sniffers, status reporters) and the single uart_tx instance; its tx_* port drives uart_tx byte_in_*.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADD_HEADER, 1, when 1 emit header byte {4'hA, id[3:0]} before each packet's payload.
- MAX_PKT_BYTES, 64, payload bytes per grant before forced release (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_data  in  NUM_REQ x 8  per-requester payload byte.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  marks final byte of packet.
- req_ready  out  NUM_REQ  per-requester byte accepted.
- tx_data  out  8  byte to uart_tx.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  uart_tx byte_in_ready.
- grant_id  out  $clog2(NUM_REQ)  current/most recent grantee.
- busy  out  1  high when state != IDLE or tx_valid high.
- pkt_truncated  out  1  one-cycle pulse when MAX_PKT_BYTES forced a release.

Behaviour:
- Reset values: tx_valid=0, req_ready=0, pkt_truncated=0, busy=0, state=IDLE, last_grant=NUM_REQ-1 so req 0 has first priority, grant_id=NUM_REQ-1, byte count=0. tx_data don't-care.
- Reset mid-packet: any byte held in the output register is dropped and the grant is lost. The requester restarts from whatever its source presents.
- Output stage:
  - Single register (tx_data, tx_valid).
  - out_free = !tx_valid || tx_ready.
  - A byte loaded while out_free sets tx_valid the next cycle.
  - tx_valid holds with tx_data stable until tx_ready.
  - Back-to-back throughput is one byte/cycle.
- State IDLE:
  - req_ready all 0.
  - If any req_valid, pick the first set bit searching cyclically from last_grant+1, then register grant_id.
  - Next state is HEADER if ADD_HEADER, else PAYLOAD. Byte count cleared.
  - Arbitration costs exactly one cycle.
- State HEADER:
  - When out_free, load {4'hA, grant_id[3:0]} and go to PAYLOAD.
  - Requester valid is not required in this state.
- State PAYLOAD:
  - req_ready[grant_id] = out_free; all other req_ready are 0.
  - On handshake (req_valid & req_ready): load req_data and increment count.
  - If req_last: set last_grant=grant_id and go to IDLE.
  - Else if count+1 == MAX_PKT_BYTES: pulse pkt_truncated, set last_grant=grant_id, go to IDLE. The remainder is sent on a later grant; under ADD_HEADER it gets a new header.
  - A grantee dropping req_valid mid-packet is allowed. The grant is held indefinitely (no timeout).
- Simultaneous requests: strict rotation. After req k finishes or is truncated, priority is k+1, k+2, ... wrapping to 0.
- Single requester repeatedly valid: it is re-granted after one IDLE cycle. No starvation of others, since the pointer advances past it.
- req_last on the MAX_PKT_BYTES-th byte: treated as normal completion, no truncation pulse.
- Count width: $clog2(MAX_PKT_BYTES+1). The counter never wraps because release happens at MAX.
- busy is combinational from state and tx_valid.
- The arbiter only tracks uart_tx occupancy through tx_ready; it has no knowledge of bit timing.

Decomposition:
- Package uart_pkg:
  - arb_state_t enum {IDLE, HEADER, PAYLOAD}.
  - localparam UART_HDR_TAG = 4'hA.
  - Function for the header byte.
- Sub-module rr_arbiter, parameter N:
  - Inputs: request vector, last_grant pointer.
  - Outputs: one-hot grant and encoded index, combinational.
  - Reusable by later debug-stream muxes.

Test Plan:
- Single packet: NUM_REQ=4, ADD_HEADER=1, req 2 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), tx_ready=1 → tx stream 0xA2,0x11,0x22,0x33. grant_id=2, busy falls after the last byte drains.
- Contention: reqs 0,1,3 each valid with a 1-byte packet (0x10,0x20,0x30) from reset → order 0,1,3 giving 0xA0,0x10,0xA1,0x20,0xA3,0x30. Then req 0 and req 3 re-request → 3 is not picked before 0 only because last_grant=3, so 0 is next.
- Backpressure: tx_ready held 0 for 20 cycles mid-packet → tx_data/tx_valid stable, req_ready[grant]=0, no byte lost or duplicated once tx_ready returns.
- Truncation: MAX_PKT_BYTES=4, req 1 sends 6 bytes with req 0 also pending → 4 payload bytes from req 1, pkt_truncated pulse once, req 0's packet, then 0xA1 plus the remaining 2 bytes.
- Reset mid-packet: assert rst during byte 2 of a 5-byte packet → next cycle tx_valid=0, req_ready=0, grant_id=NUM_REQ-1. After release, req 0 wins if valid.
- ADD_HEADER=0, back-to-back: req 0 streams 8 bytes with tx_ready=1 → one byte/cycle after a 1-cycle arbitration gap, no header bytes emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx byte-stream arbiter.
// Holds the arbiter FSM encoding and the format of the per-packet header byte.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_t;

  localparam logic [3:0] UART_HDR_TAG = 4'hA;

  // The upper nibble tags the byte as a header; the lower nibble names the requester.
  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {UART_HDR_TAG, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, cyclically.
// Returns both a one-hot grant and its encoded index; both are zero when no request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    // Offsets start at 1 so the previous grantee is searched last.
    for (int i = 1; i <= N; i++) begin
      j = (int'(last_grant) + i) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx byte interface among NUM_REQ sources.
// Handshakes: a byte moves on any cycle where valid and ready are both high at the clock edge.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADD_HEADER    = 1,
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0][7:0]    req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       pkt_truncated
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_BYTES + 1);

  arb_state_t    state, state_d;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [GW-1:0] arb_idx;
  logic          any_req;
  logic          out_free;
  logic          load;
  logic [7:0]    load_data;
  logic          release_grant;
  logic          trunc;

  rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign any_req  = |arb_gnt;
  assign out_free = !tx_valid || tx_ready;
  assign busy     = (state != IDLE) || tx_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d       = state;
    load          = 1'b0;
    load_data     = req_data[grant_id];
    release_grant = 1'b0;
    trunc         = 1'b0;
    req_ready     = '0;
    case (state)
      IDLE: begin
        if (any_req) state_d = (ADD_HEADER != 0) ? HEADER : PAYLOAD;
      end
      HEADER: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = hdr_byte(4'(grant_id));
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        req_ready[grant_id] = out_free;
        if (req_valid[grant_id] && out_free) begin
          load = 1'b1;
          // A last byte landing exactly on the limit is a normal completion.
          if (req_last[grant_id]) begin
            release_grant = 1'b1;
            state_d       = IDLE;
          end else if (int'(cnt) + 1 == MAX_PKT_BYTES) begin
            release_grant = 1'b1;
            trunc         = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= GW'(NUM_REQ - 1);
      grant_id      <= GW'(NUM_REQ - 1);
      cnt           <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      pkt_truncated <= 1'b0;
    end else begin
      pkt_truncated <= trunc;
      if (state == IDLE && any_req) begin
        grant_id <= arb_idx;
        cnt      <= '0;
      end else if (load && state == PAYLOAD) begin
        cnt <= cnt + CW'(1);
      end
      if (release_grant) last_grant <= grant_id;
      // Output register: refill whenever free, otherwise hold until uart_tx takes it.
      if (load) begin
        tx_data  <= load_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: header/truncating instance (MAX=4) and a headerless MAX=64 instance.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0][7:0] a_req_data, b_req_data;
  logic [3:0]      a_req_valid, a_req_last, a_req_ready;
  logic [3:0]      b_req_valid, b_req_last, b_req_ready;
  logic [7:0]      a_tx_data, b_tx_data;
  logic            a_tx_valid, a_tx_ready, b_tx_valid, b_tx_ready;
  logic [1:0]      a_grant_id, b_grant_id;
  logic            a_busy, b_busy, a_pkt_truncated, b_pkt_truncated;

  uart_tx_arbiter #(.NUM_REQ(4), .ADD_HEADER(1), .MAX_PKT_BYTES(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_data(a_req_data), .req_valid(a_req_valid), .req_last(a_req_last), .req_ready(a_req_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .grant_id(a_grant_id), .busy(a_busy), .pkt_truncated(a_pkt_truncated)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .ADD_HEADER(0), .MAX_PKT_BYTES(64)) dut_b (
    .clk(clk), .rst(rst),
    .req_data(b_req_data), .req_valid(b_req_valid), .req_last(b_req_last), .req_ready(b_req_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .grant_id(b_grant_id), .busy(b_busy), .pkt_truncated(b_pkt_truncated)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-requester sources hold {last, data}; exp_q is the expected tx byte stream.
  logic [8:0] src_q [4][$];
  logic [7:0] exp_q [$];
  logic [8:0] b_src [$];
  logic [7:0] b_exp [$];
  logic       tx_rdy_drv = 1'b1;
  int         fired      = 0;
  int         trunc_seen = 0;

  // Inputs change on the falling edge; handshakes are judged just after, before the rising edge.
  task automatic a_cycle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        a_req_valid[i] = 1'b1;
        a_req_data[i]  = src_q[i][0][7:0];
        a_req_last[i]  = src_q[i][0][8];
      end else begin
        a_req_valid[i] = 1'b0;
        a_req_data[i]  = 8'h00;
        a_req_last[i]  = 1'b0;
      end
    end
    a_tx_ready = tx_rdy_drv;
    #1;
    if (!rst) begin
      if (a_pkt_truncated) trunc_seen++;
      if (a_tx_valid && a_tx_ready) begin
        if (exp_q.size() == 0) check("tx_unexpected_byte", a_tx_valid, 1'b0);
        else                   check("tx_byte", a_tx_data, exp_q.pop_front());
        fired++;
      end
      for (int i = 0; i < 4; i++)
        if (a_req_valid[i] && a_req_ready[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    a_cycle();
    a_cycle();
    rst        = 1'b0;
    fired      = 0;
    trunc_seen = 0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      a_cycle();
      n++;
    end while (!(exp_q.size() == 0 && !a_busy) && n < budget);
    check({tag, "_drained"}, (exp_q.size() == 0 && !a_busy), 1'b1);
  endtask

  task automatic run_until_fired(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (fired < target && n < budget) begin
      a_cycle();
      n++;
    end
    check({tag, "_reached"}, fired >= target, 1'b1);
  endtask

  task automatic push_pkt(input int id, input logic [7:0] first, input int len);
    for (int k = 0; k < len; k++)
      src_q[id].push_back({(k == len - 1), first + 8'(k)});
  endtask

  initial begin
    a_req_data = '0; a_req_valid = '0; a_req_last = '0; a_tx_ready = 1'b1;
    b_req_data = '0; b_req_valid = '0; b_req_last = '0; b_tx_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_tx_valid",  a_tx_valid, 1'b0);
    check("rst_req_ready", a_req_ready, 4'h0);
    check("rst_busy",      a_busy, 1'b0);
    check("rst_grant_id",  a_grant_id, 2'd3);
    check("rst_trunc",     a_pkt_truncated, 1'b0);

    // Single packet from req 2
    push_pkt(2, 8'h11, 1);
    src_q[2][0] = {1'b0, 8'h11};
    src_q[2].push_back({1'b0, 8'h22});
    src_q[2].push_back({1'b1, 8'h33});
    exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
    run_until_idle("single", 60);
    check("single_grant", a_grant_id, 2'd2);
    check("single_busy",  a_busy, 1'b0);

    // Contention from reset: 0, 1, 3, then 0 ahead of 3
    do_reset();
    push_pkt(0, 8'h10, 1);
    push_pkt(1, 8'h20, 1);
    push_pkt(3, 8'h30, 1);
    exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h20, 8'hA3, 8'h30};
    run_until_idle("contend1", 80);
    check("contend1_grant", a_grant_id, 2'd3);
    push_pkt(0, 8'h40, 1);
    push_pkt(3, 8'h50, 1);
    exp_q = '{8'hA0, 8'h40, 8'hA3, 8'h50};
    run_until_idle("contend2", 80);
    check("contend2_grant", a_grant_id, 2'd3);

    // Backpressure mid-packet; last byte lands exactly on the limit
    do_reset();
    push_pkt(1, 8'h61, 4);
    exp_q = '{8'hA1, 8'h61, 8'h62, 8'h63, 8'h64};
    run_until_fired("bp_start", 2, 40);
    tx_rdy_drv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      a_cycle();
      check("bp_tx_valid",  a_tx_valid, 1'b1);
      check("bp_tx_data",   a_tx_data, exp_q[0]);
      check("bp_req_ready", a_req_ready[1], 1'b0);
    end
    tx_rdy_drv = 1'b1;
    run_until_idle("bp", 60);
    check("bp_no_trunc", trunc_seen, 0);

    // Truncation at 4 payload bytes with req 0 waiting
    do_reset();
    push_pkt(1, 8'h71, 6);
    exp_q = '{8'hA1, 8'h71, 8'h72, 8'h73, 8'h74, 8'hA0, 8'h80, 8'hA1, 8'h75, 8'h76};
    run_until_fired("trunc_start", 1, 40);
    push_pkt(0, 8'h80, 1);
    run_until_idle("trunc", 100);
    check("trunc_pulses", trunc_seen, 1);
    check("trunc_grant",  a_grant_id, 2'd1);

    // Reset mid-packet
    do_reset();
    push_pkt(2, 8'h91, 5);
    exp_q = '{8'hA2, 8'h91, 8'h92, 8'h93, 8'h94};
    run_until_fired("rstmid_start", 2, 40);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    a_cycle();
    rst = 1'b0;
    a_cycle();
    check("rstmid_tx_valid",  a_tx_valid, 1'b0);
    check("rstmid_req_ready", a_req_ready, 4'h0);
    check("rstmid_grant_id",  a_grant_id, 2'd3);
    check("rstmid_busy",      a_busy, 1'b0);
    push_pkt(0, 8'hB0, 1);
    push_pkt(2, 8'h91, 3);
    exp_q = '{8'hA0, 8'hB0, 8'hA2, 8'h91, 8'h92, 8'h93};
    run_until_idle("rstmid", 80);

    // Headerless instance: 8 bytes from req 0 at one per cycle after one arbitration cycle
    begin
      int k;
      k = 0;
      for (int i = 0; i < 8; i++) begin
        b_src.push_back({(i == 7), 8'hC0 + 8'(i)});
        b_exp.push_back(8'hC0 + 8'(i));
      end
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        b_req_valid[0] = (b_src.size() > 0);
        b_req_data[0]  = (b_src.size() > 0) ? b_src[0][7:0] : 8'h00;
        b_req_last[0]  = (b_src.size() > 0) ? b_src[0][8] : 1'b0;
        b_tx_ready     = 1'b1;
        #1;
        if (b_tx_valid && b_tx_ready) begin
          if (b_exp.size() == 0) check("b_unexpected_byte", b_tx_valid, 1'b0);
          else                   check("b_byte", b_tx_data, b_exp.pop_front());
          check("b_byte_cycle", c, 2 + k);
          k++;
        end
        if (b_req_valid[0] && b_req_ready[0]) void'(b_src.pop_front());
      end
      check("b_byte_count", k, 8);
      check("b_busy",       b_busy, 1'b0);
      check("b_grant",      b_grant_id, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
